// File: rtl/dcache_assoc.sv
// N-way set-associative, write-back, write-allocate L1 data cache with round-robin replacement.
// Optional performance counters are built when DCACHE_PERF_COUNTERS_EN is defined.
package dcache_assoc_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
    typedef enum logic [1:0] {LOAD = 2'd0, STORE = 2'd1, CLFLUSH = 2'd2} memory_operation_e;
endpackage

module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int XLEN       = 32,
    parameter int WAYS       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        pipe_req_address,
    input  memory_operation_size_e pipe_req_size,
    input  memory_operation_e      pipe_req_type,
    input  logic                   pipe_req_valid,
    input  logic [XLEN-1:0]        pipe_word_to_store,
    output logic [XLEN-1:0]        pipe_fetched_word,
    output logic                   pipe_req_fulfilled,
    output logic [XLEN-1:0]        l2_req_address,
    output memory_operation_e      l2_req_type,
    output logic                   l2_req_valid,
    output logic [XLEN-1:0]        l2_word_to_store,
    input  logic [XLEN-1:0]        l2_fetched_word,
    input  logic                   l2_req_fulfilled,
    output logic [1:0]             dbg_state
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]            perf_hits,
    output logic [31:0]            perf_misses,
    output logic [31:0]            perf_writebacks
`endif
);
    localparam int WORDS    = LINE_SIZE / 4;
    localparam int SETS     = CACHE_SIZE / (LINE_SIZE * WAYS);
    localparam int OFFSET_W = $clog2(LINE_SIZE);
    localparam int INDEX_W  = $clog2(SETS);
    localparam int TAG_W    = XLEN - OFFSET_W - INDEX_W;
    localparam int IDX_W    = (INDEX_W > 0) ? INDEX_W : 1;
    localparam int WCNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_WRITEBACK = 2'd2;
    localparam logic [1:0] S_FILL      = 2'd3;

    logic [1:0]                   state_q;
    logic [XLEN-1:0]              req_addr_q;
    logic [XLEN-1:0]              req_data_q;
    memory_operation_size_e       req_size_q;
    memory_operation_e            req_type_q;
    logic                         refill_q;
    logic [WAY_W-1:0]             victim_q;
    logic [WCNT_W-1:0]            wcnt_q;

    logic [XLEN-1:0]              data_q [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]             tag_q  [WAYS][SETS];
    logic [SETS-1:0][WAYS-1:0]    valid_q;
    logic [SETS-1:0][WAYS-1:0]    dirty_q;
    logic [SETS-1:0][WAY_W-1:0]   rr_q;

    logic [TAG_W-1:0]             req_tag;
    logic [IDX_W-1:0]             req_idx;
    logic [WCNT_W-1:0]            req_word;
    logic [WCNT_W-1:0]            wcnt_nxt;
    logic                         wcnt_last;
    logic                         l2_done;
    logic                         hit;
    logic [WAY_W-1:0]             hit_way;
    logic                         inv_found;
    logic [WAY_W-1:0]             inv_way;
    logic [WAY_W-1:0]             miss_way;
    logic [XLEN-1:0]              hit_word;
    logic                         fill_last;
    logic                         data_we;
    logic [WAY_W-1:0]             data_way;
    logic [WCNT_W-1:0]            data_word;
    logic [XLEN-1:0]              data_wdata;

    function automatic logic [XLEN-1:0] word_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [WCNT_W-1:0] w);
        return {t, {(XLEN-TAG_W){1'b0}}} | (XLEN'(i) << OFFSET_W) | (XLEN'(w) << 2);
    endfunction

    function automatic logic [XLEN-1:0] load_lane(input logic [XLEN-1:0] w,
                                                  input memory_operation_size_e sz,
                                                  input logic [1:0] off);
        case (sz)
            BYTE:    return {24'b0, w[{off, 3'b000} +: 8]};
            HALF:    return {16'b0, w[{off[1], 4'b0000} +: 16]};
            default: return w;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old,
                                                    input logic [XLEN-1:0] d,
                                                    input memory_operation_size_e sz,
                                                    input logic [1:0] off);
        logic [XLEN-1:0] r;
        r = old;
        case (sz)
            BYTE:    r[{off, 3'b000} +: 8] = d[7:0];
            HALF:    r[{off[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    assign req_tag   = req_addr_q[XLEN-1 -: TAG_W];
    assign req_idx   = (SETS > 1) ? req_addr_q[OFFSET_W +: IDX_W] : '0;
    assign req_word  = (WORDS > 1) ? req_addr_q[2 +: WCNT_W] : '0;
    assign wcnt_nxt  = wcnt_q + 1'b1;
    assign wcnt_last = (wcnt_q == WCNT_W'(WORDS - 1));
    // A fulfil pulse only counts while our request is up; stray pulses are ignored.
    assign l2_done   = l2_req_valid && l2_req_fulfilled;
    assign fill_last = (state_q == S_FILL) && l2_done && wcnt_last;
    assign dbg_state = state_q;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        miss_way = inv_found ? inv_way : rr_q[req_idx];
        hit_word = data_q[hit_way][req_idx][req_word];
    end

    always_comb begin
        data_we    = 1'b0;
        data_way   = hit_way;
        data_word  = req_word;
        data_wdata = store_merge(hit_word, req_data_q, req_size_q, req_addr_q[1:0]);
        if ((state_q == S_COMPARE) && (req_type_q == STORE) && hit) begin
            data_we = 1'b1;
        end else if ((state_q == S_FILL) && l2_done) begin
            data_we    = 1'b1;
            data_way   = victim_q;
            data_word  = wcnt_q;
            data_wdata = l2_fetched_word;
        end
    end

    // Line storage and tags carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[data_way][req_idx][data_word] <= data_wdata;
        end
        if (fill_last) begin
            tag_q[victim_q][req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= S_IDLE;
            req_addr_q         <= '0;
            req_data_q         <= '0;
            req_size_q         <= WORD;
            req_type_q         <= LOAD;
            refill_q           <= 1'b0;
            victim_q           <= '0;
            wcnt_q             <= '0;
            valid_q            <= '0;
            dirty_q            <= '0;
            rr_q               <= '0;
            pipe_fetched_word  <= '0;
            pipe_req_fulfilled <= 1'b0;
            l2_req_valid       <= 1'b0;
            l2_req_address     <= '0;
            l2_req_type        <= LOAD;
            l2_word_to_store   <= '0;
        end else begin
            pipe_req_fulfilled <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    refill_q <= 1'b0;
                    if (pipe_req_valid) begin
                        req_addr_q <= pipe_req_address;
                        req_data_q <= pipe_word_to_store;
                        req_size_q <= pipe_req_size;
                        req_type_q <= pipe_req_type;
                        state_q    <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    wcnt_q <= '0;
                    if (req_type_q == CLFLUSH) begin
                        if (hit && dirty_q[req_idx][hit_way]) begin
                            victim_q <= hit_way;
                            state_q  <= S_WRITEBACK;
                        end else begin
                            if (hit) valid_q[req_idx][hit_way] <= 1'b0;
                            pipe_req_fulfilled <= 1'b1;
                            state_q            <= S_IDLE;
                        end
                    end else if (hit) begin
                        if (req_type_q == STORE) begin
                            dirty_q[req_idx][hit_way] <= 1'b1;
                        end else begin
                            pipe_fetched_word <= load_lane(hit_word, req_size_q, req_addr_q[1:0]);
                        end
                        pipe_req_fulfilled <= 1'b1;
                        state_q            <= S_IDLE;
                    end else begin
                        refill_q <= 1'b1;
                        victim_q <= miss_way;
                        if (valid_q[req_idx][miss_way] && dirty_q[req_idx][miss_way]) begin
                            state_q <= S_WRITEBACK;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!l2_req_valid) begin
                        l2_req_valid     <= 1'b1;
                        l2_req_type      <= STORE;
                        l2_req_address   <= word_addr(tag_q[victim_q][req_idx], req_idx, wcnt_q);
                        l2_word_to_store <= data_q[victim_q][req_idx][wcnt_q];
                    end else if (l2_req_fulfilled) begin
                        if (wcnt_last) begin
                            wcnt_q                     <= '0;
                            l2_req_valid               <= 1'b0;
                            dirty_q[req_idx][victim_q] <= 1'b0;
                            if (req_type_q == CLFLUSH) begin
                                valid_q[req_idx][victim_q] <= 1'b0;
                                pipe_req_fulfilled         <= 1'b1;
                                state_q                    <= S_IDLE;
                            end else begin
                                state_q <= S_FILL;
                            end
                        end else begin
                            wcnt_q           <= wcnt_nxt;
                            l2_req_address   <= word_addr(tag_q[victim_q][req_idx], req_idx, wcnt_nxt);
                            l2_word_to_store <= data_q[victim_q][req_idx][wcnt_nxt];
                        end
                    end
                end
                S_FILL: begin
                    if (!l2_req_valid) begin
                        l2_req_valid   <= 1'b1;
                        l2_req_type    <= LOAD;
                        l2_req_address <= word_addr(req_tag, req_idx, wcnt_q);
                    end else if (l2_req_fulfilled) begin
                        if (wcnt_last) begin
                            wcnt_q                     <= '0;
                            l2_req_valid               <= 1'b0;
                            valid_q[req_idx][victim_q] <= 1'b1;
                            dirty_q[req_idx][victim_q] <= 1'b0;
                            rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;
                            state_q                    <= S_COMPARE;
                        end else begin
                            wcnt_q         <= wcnt_nxt;
                            l2_req_address <= word_addr(req_tag, req_idx, wcnt_nxt);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    logic count_hit, count_miss, count_wb;

    // The compare that follows a refill always hits and is not a new access.
    assign count_hit  = (state_q == S_COMPARE) && (req_type_q != CLFLUSH) && !refill_q && hit;
    assign count_miss = (state_q == S_COMPARE) && (req_type_q != CLFLUSH) && !refill_q && !hit;
    assign count_wb   = (state_q == S_WRITEBACK) && l2_done && wcnt_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (count_hit && (perf_hits != '1)) perf_hits <= perf_hits + 1'b1;
            if (count_miss && (perf_misses != '1)) perf_misses <= perf_misses + 1'b1;
            if (count_wb && (perf_writebacks != '1)) perf_writebacks <= perf_writebacks + 1'b1;
        end
    end
`endif

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised successor to the direct-mapped data cache: an N-way set-associative, write-back, write-allocate L1 data cache in a single module with an integrated FSM.
- Sits between the pipeline load/store unit (pipe_* interface) and L2 (l2_* interface, one word per transaction).
- New relative to the direct-mapped block: configurable associativity, per-set round-robin replacement, byte/half/word stores, CLFLUSH line flush, optional performance counters.

Parameters:
- LINE_SIZE, 32, bytes per line; power of two, >= 4.
- CACHE_SIZE, 1024, total data bytes; power of two.
- XLEN, 32, address/data width; fixed at 32 in this generation.
- WAYS, 2, associativity; power of two, >= 1.
- Derived values:
  - WORDS = LINE_SIZE/4.
  - SETS = CACHE_SIZE/(LINE_SIZE*WAYS); must be >= 1.
  - OFFSET_W = log2(LINE_SIZE), INDEX_W = log2(SETS), TAG_W = XLEN-OFFSET_W-INDEX_W.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pipe_req_address  in  XLEN  byte address.
- pipe_req_size  in  memory_operation_size_e  BYTE/HALF/WORD.
- pipe_req_type  in  memory_operation_e  LOAD/STORE/CLFLUSH.
- pipe_req_valid  in  1  request valid; held with stable fields until fulfilled.
- pipe_word_to_store  in  XLEN  store data, right-aligned.
- pipe_fetched_word  out  XLEN  load data, right-aligned, zero-extended.
- pipe_req_fulfilled  out  1  one-cycle completion pulse.
- l2_req_address  out  XLEN  word-aligned L2 address.
- l2_req_type  out  memory_operation_e  LOAD (fill) or STORE (writeback).
- l2_req_valid  out  1  L2 request valid.
- l2_word_to_store  out  XLEN  writeback data.
- l2_fetched_word  in  XLEN  fill data, valid when fulfilled.
- l2_req_fulfilled  in  1  L2 completion pulse for the current word.

Behaviour:
- Reset (reset=0, asynchronous):
  - All valid/dirty bits and round-robin pointers clear; FSM to IDLE.
  - Outputs: pipe_fetched_word=0, pipe_req_fulfilled=0, l2_req_valid=0, l2_req_address=0, l2_req_type=LOAD, l2_word_to_store=0.
  - Reset mid-transaction abandons the transaction; l2_req_valid drops immediately; data array contents are don't-care.
- Address decode: tag=addr[XLEN-1:OFFSET_W+INDEX_W], index=addr[OFFSET_W+INDEX_W-1:OFFSET_W], word=addr[OFFSET_W-1:2].
- Alignment: HALF ignores addr[0]; WORD ignores addr[1:0].
- FSM states:
  - IDLE: on pipe_req_valid, register the request -> COMPARE.
  - COMPARE: tag match across all ways of the set.
    - LOAD hit: pipe_req_fulfilled=1, pipe_fetched_word=selected lane(s) zero-extended -> IDLE.
    - STORE hit: merge byte lane addr[1:0] / half lane addr[1] / whole word; set dirty; fulfilled -> IDLE.
    - CLFLUSH hit, dirty -> WRITEBACK (flush). CLFLUSH hit, clean: clear valid, fulfilled -> IDLE. CLFLUSH miss: fulfilled, no L2 traffic.
    - LOAD/STORE miss: victim = lowest-index invalid way, else the set's round-robin pointer. Victim valid and dirty -> WRITEBACK; otherwise -> FILL.
  - WRITEBACK: WORDS L2 STORE transactions, offsets 0..WORDS-1 ascending, address = {victim tag, index, word, 2'b00}.
    - Ends with the line's dirty bit cleared.
    - Flush: clear valid, fulfilled -> IDLE. Miss: -> FILL.
  - FILL: WORDS L2 LOAD transactions, ascending from offset 0; each l2_fetched_word written into the victim way when l2_req_fulfilled=1.
    - After the last word: valid=1, dirty=0, tag written, pointer advanced by one (mod WAYS) -> COMPARE, which now hits.
- L2 handshake:
  - l2_req_valid registered and held continuously through all WORDS transactions of a phase.
  - Address/data advance the cycle after each l2_req_fulfilled.
  - l2_req_valid is low the cycle after the final fulfilled.
  - l2_req_fulfilled while l2_req_valid=0 is ignored.
- Latency: hit fulfilled 2 cycles after pipe_req_valid first seen (IDLE, COMPARE). pipe_req_fulfilled never asserts in consecutive cycles.
- Word counter is log2(WORDS) bits, wraps to 0 at phase end.

Optional Feature:
- Macro DCACHE_PERF_COUNTERS_EN.
- Defined: adds outputs perf_hits, perf_misses, perf_writebacks (each 32 bits).
  - Reset to 0; saturate at 0xFFFF_FFFF.
  - Hits/misses count once per LOAD/STORE at its first COMPARE; writebacks count once per line written back.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
Defaults (16 sets); 0x1000/0x2000/0x3000 map to set 0; L2 model returns the address as data unless stated.
- Cold LOAD WORD 0x1000 -> 8 L2 LOADs 0x1000..0x101C, then fulfilled with 0x00001000; LOAD 0x1004 -> fulfilled 2 cycles later with 0x00001004, no l2_req_valid.
- Line 0x1000 filled with word 0x11223344 at 0x1000; STORE BYTE 0xAB to 0x1001 -> LOAD WORD 0x1000 returns 0x1122AB44; LOAD HALF 0x1002 returns 0x00001122.
- Dirty 0x1000 (way0), LOAD 0x2000 fills way1, LOAD 0x3000 -> evicts way0: 8 L2 STOREs 0x1000..0x101C (first data 0x1122AB44), then 8 LOADs 0x3000..0x301C.
- CLFLUSH 0x2000 clean -> fulfilled, no L2 traffic; next LOAD 0x2000 misses (8 fills). CLFLUSH of dirty line -> 8 STOREs then fulfilled; CLFLUSH 0x5000 (miss) -> fulfilled, no traffic.
- reset low during 4th writeback word -> l2_req_valid 0 in the same cycle; after release, LOAD 0x1000 misses.
- With DCACHE_PERF_COUNTERS_EN: run the eviction scenario from reset -> perf_hits=0, perf_misses=3, perf_writebacks=1.
